// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with double-buffered
// digit image, per-digit dp/blank/blink, and registered active-low outputs.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [7:0]              seg_out,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS-1:0]      blink;
  } img_t;

  localparam img_t ACT_RST = '{dig: '0, dp: '0, blank: '1, blink: '0};

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;  default: glyph = 7'h42; // F drawn as "G"
    endcase
  endfunction

  logic [PW-1:0] presc;
  logic [IW-1:0] idx, idx_nxt;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase, phase_nxt;
  logic          pend_valid;
  img_t          pend_q, act_q, act_nxt, in_img;
  logic          tick, wrap, dark;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [7:0]    seg_nxt;

  assign in_img = '{dig: digits_in, dp: dp_in, blank: blank_in, blink: blink_in};

  // Everything the new slot needs is computed from post-edge values so a
  // commit (or same-cycle bypass load) shows up in the digit 0 slot at once.
  always_comb begin
    tick      = (presc == PW'(SCAN_DIV - 1));
    wrap      = tick && (idx == IW'(NUM_DIGITS - 1));
    idx_nxt   = wrap ? '0 : idx + IW'(1);
    phase_nxt = blink_phase ^ (wrap && (frame_cnt == FW'(BLINK_FRAMES - 1)));
    act_nxt   = act_q;
    if (wrap) begin
      if (load)            act_nxt = in_img;
      else if (pend_valid) act_nxt = pend_q;
    end
    dark    = act_nxt.blank[idx_nxt] | (act_nxt.blink[idx_nxt] & phase_nxt);
    an_nxt  = dark ? '1 : ~(NUM_DIGITS'(1) << idx_nxt);
    seg_nxt = dark ? 8'hFF : {~act_nxt.dp[idx_nxt], glyph(act_nxt.dig[idx_nxt])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      pend_valid  <= 1'b0;
      pend_q      <= '0;
      act_q       <= ACT_RST;
      an_out      <= '1;
      seg_out     <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      presc       <= tick ? '0 : presc + PW'(1);
      act_q       <= act_nxt;
      blink_phase <= phase_nxt;
      frame_start <= wrap;
      if (tick) begin
        idx     <= idx_nxt;
        an_out  <= an_nxt;
        seg_out <= seg_nxt;
      end
      if (wrap)
        frame_cnt <= (frame_cnt == FW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + FW'(1);
      if (load && !wrap) begin
        pend_q     <= in_img;
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed + randomized bench for seg_scan_driver against a behavioural
// display model built from integer counters and digit arrays.
module tb_seg_scan_driver;
  localparam int ND = 4, SD = 4, BF = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   digits = '0;
  logic [3:0]    dp = '0, blank = '0, blink = '0;
  logic          load = 1'b0;
  logic [3:0]    an_out;
  logic [7:0]    seg_out;
  logic          frame_start;

  seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digits_in(digits), .dp_in(dp), .blank_in(blank),
    .blink_in(blink), .load(load), .an_out(an_out), .seg_out(seg_out),
    .frame_start(frame_start));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // reference: glyphs copied from the segment table, g..a
  logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h42};
  int  m_cycle, m_slot, m_frames;
  bit  m_phase, m_pv;
  int  pend_dig [ND], act_dig [ND];
  bit  pend_dp [ND], pend_bl [ND], pend_bk [ND];
  bit  act_dp [ND], act_bl [ND], act_bk [ND];
  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic       e_fs;

  task automatic m_reset();
    m_cycle = 0; m_slot = 0; m_frames = 0; m_phase = 0; m_pv = 0;
    for (int i = 0; i < ND; i++) begin
      pend_dig[i] = 0; pend_dp[i] = 0; pend_bl[i] = 0; pend_bk[i] = 0;
      act_dig[i] = 0;  act_dp[i] = 0;  act_bl[i] = 1;  act_bk[i] = 0;
    end
    e_an = 4'hF; e_seg = 8'hFF; e_fs = 0;
  endtask

  // advance the model by one clock using the inputs presented at that edge
  task automatic m_step();
    bit slot_end, frame_end, dark;
    if (rst) begin m_reset(); return; end
    slot_end  = (m_cycle == SD - 1);
    frame_end = slot_end && (m_slot == ND - 1);
    m_cycle = (m_cycle + 1) % SD;
    if (load && !frame_end) begin
      for (int i = 0; i < ND; i++) begin
        pend_dig[i] = digits[4*i +: 4]; pend_dp[i] = dp[i];
        pend_bl[i] = blank[i]; pend_bk[i] = blink[i];
      end
      m_pv = 1;
    end
    if (frame_end) begin
      if (load) begin
        for (int i = 0; i < ND; i++) begin
          act_dig[i] = digits[4*i +: 4]; act_dp[i] = dp[i];
          act_bl[i] = blank[i]; act_bk[i] = blink[i];
        end
      end else if (m_pv) begin
        for (int i = 0; i < ND; i++) begin
          act_dig[i] = pend_dig[i]; act_dp[i] = pend_dp[i];
          act_bl[i] = pend_bl[i]; act_bk[i] = pend_bk[i];
        end
      end
      m_pv = 0;
      m_frames++;
      if (m_frames == BF) begin m_frames = 0; m_phase = !m_phase; end
    end
    if (slot_end) begin
      m_slot = (m_slot + 1) % ND;
      dark = act_bl[m_slot] || (act_bk[m_slot] && m_phase);
      e_an = 4'hF;
      if (!dark) e_an[m_slot] = 1'b0;
      e_seg = dark ? 8'hFF : {!act_dp[m_slot], glyph_tbl[act_dig[m_slot]]};
    end
    e_fs = frame_end;
  endtask

  task automatic check_outs(input string tag);
    n_checks += 3;
    assert (an_out === e_an) else begin
      n_fail++; $error("FAIL %s an_out: got %b want %b (t=%0t)", tag, an_out, e_an, $time);
    end
    assert (seg_out === e_seg) else begin
      n_fail++; $error("FAIL %s seg_out: got %h want %h (t=%0t)", tag, seg_out, e_seg, $time);
    end
    assert (frame_start === e_fs) else begin
      n_fail++; $error("FAIL %s frame_start: got %b want %b (t=%0t)", tag, frame_start, e_fs, $time);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    m_step();
    #1 check_outs(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  task automatic set_img(input logic [15:0] d, input logic [3:0] p, bl, bk);
    digits = d; dp = p; blank = bl; blink = bk;
  endtask

  task automatic wait_slot(input int slot, input bit at_tick, input string tag);
    int guard = 0;
    while (!(m_slot == slot && (!at_tick || m_cycle == SD - 1)) && guard < 100) begin
      cycle(tag); guard++;
    end
    n_checks++;
    assert (guard < 100) else begin
      n_fail++; $error("FAIL %s wait: got timeout want slot %0d", tag, slot);
    end
  endtask

  int fs_count;

  initial begin
    m_reset();
    run(2, "reset");
    rst = 0;
    run(24, "idle");

    set_img(16'h3210, 4'b0100, 4'b0000, 4'b0000);
    load = 1; cycle("load1"); load = 0;
    wait_slot(3, 1'b1, "sync1");
    cycle("commit1");
    n_checks += 2;
    assert (an_out === 4'b1110 && seg_out === 8'hC0) else begin
      n_fail++; $error("FAIL first_slot: got %b/%h want 1110/c0", an_out, seg_out);
    end
    assert (frame_start === 1'b1) else begin
      n_fail++; $error("FAIL first_fs: got %b want 1", frame_start);
    end
    fs_count = 0;
    for (int k = 0; k < 32; k++) begin cycle("frame"); fs_count += frame_start; end
    n_checks++;
    assert (fs_count == 2) else begin
      n_fail++; $error("FAIL fs_rate: got %0d want 2", fs_count);
    end

    wait_slot(2, 1'b0, "sync2");
    set_img(16'hFEDC, 4'b0000, 4'b0000, 4'b0000);
    load = 1; cycle("midload"); load = 0;
    run(40, "newframe");

    set_img(16'h3210, 4'b0000, 4'b0000, 4'b0001);
    load = 1; cycle("blinkload"); load = 0;
    run(140, "blink");

    wait_slot(3, 1'b1, "sync5");
    set_img(16'h5555, 4'b0000, 4'b0000, 4'b0000);
    load = 1; cycle("bypass"); load = 0;
    n_checks++;
    assert (an_out === 4'b1110 && seg_out === 8'h92) else begin
      n_fail++; $error("FAIL bypass: got %b/%h want 1110/92", an_out, seg_out);
    end
    set_img(16'h1111, 4'b1111, 4'b0000, 4'b0000);
    run(40, "after_bypass");

    wait_slot(2, 1'b0, "sync6");
    set_img(16'hAAAA, 4'b0000, 4'b0000, 4'b0000);
    load = 1; cycle("preload"); load = 0;
    rst = 1; cycle("midrst"); rst = 0;
    n_checks++;
    assert (an_out === 4'hF && seg_out === 8'hFF) else begin
      n_fail++; $error("FAIL midrst: got %b/%h want 1111/ff", an_out, seg_out);
    end
    run(40, "post_rst");

    for (int k = 0; k < 600; k++) begin
      load = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      set_img(16'($urandom), 4'($urandom), 4'($urandom & $urandom & $urandom),
              4'($urandom & $urandom));
      cycle("random");
    end
    load = 0; rst = 0;
    run(8, "tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
